// File: rtl/oc8051_xram_responder.sv
// External-RAM slave for the shared arbiter bus.
// It adds programmable wait states and blocks user-mode access to one protected address window.
module oc8051_xram_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] PROT_BASE   = 16'h0300,
    parameter logic [15:0] PROT_LIMIT  = 16'h03FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        priv_lvl,
    output logic        ack,
    output logic [7:0]  data_out,
    output logic        viol
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 2 ** ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              req_wr;
    logic              req_priv;
    logic [15:0]       req_addr;
    logic [7:0]        req_data;
    logic [7:0]        mem [DEPTH];

    logic              capture;
    logic              enter_ack;
    logic              cur_wr;
    logic              cur_priv;
    logic [15:0]       cur_addr;
    logic [7:0]        cur_data;
    logic              denied;
    logic [ADDR_W-1:0] mem_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        enter_ack = 1'b0;
        case (state)
            IDLE: begin
                if (stb) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ACK;
                    enter_ack = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With zero wait states the ACK-entry edge is the capture edge itself,
    // so the live bus values stand in for the not-yet-latched request.
    always_comb begin
        cur_wr   = req_wr;
        cur_priv = req_priv;
        cur_addr = req_addr;
        cur_data = req_data;
        if (state == IDLE) begin
            cur_wr   = wr;
            cur_priv = priv_lvl;
            cur_addr = addr;
            cur_data = data_in;
        end
        denied  = !cur_priv && (cur_addr >= PROT_BASE) && (cur_addr <= PROT_LIMIT);
        mem_idx = cur_addr[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            ack      <= 1'b0;
            viol     <= 1'b0;
            data_out <= 8'h00;
            req_wr   <= 1'b0;
            req_priv <= 1'b0;
            req_addr <= 16'h0000;
            req_data <= 8'h00;
        end else begin
            if (capture) begin
                req_wr   <= wr;
                req_priv <= priv_lvl;
                req_addr <= addr;
                req_data <= data_in;
                cnt      <= WAIT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            ack  <= enter_ack;
            viol <= enter_ack && denied;
            if (enter_ack && !cur_wr) begin
                data_out <= denied ? 8'h00 : mem[mem_idx];
            end
        end
    end

    // The array is never cleared; a reset before the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && cur_wr && !denied) begin
            mem[mem_idx] <= cur_data;
        end
    end

endmodule

// File: tb/tb_oc8051_xram_responder.sv
// Scoreboard bench for oc8051_xram_responder.
// It runs three instances with WAIT_CYCLES of 2, 0 and 3 against a reference memory model.
module tb_oc8051_xram_responder;

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] data;
        logic       viol;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  stb;
    logic [2:0]  wr;
    logic [2:0]  priv;
    logic [2:0]  ack;
    logic [2:0]  viol;
    logic [15:0] addr [3];
    logic [7:0]  din  [3];
    logic [7:0]  dout [3];

    int          cyc;
    int          nCompared;
    int          nFailed;
    exp_t        sbq [$];
    logic [7:0]  mdl    [3][1024];
    logic [7:0]  lastRd [3];

    // Instance 0 waits 2 cycles, instance 1 waits 0 cycles and instance 2 waits 3 cycles.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        oc8051_xram_responder #(
            .ADDR_W     (10),
            .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 3)),
            .PROT_BASE  (16'h0300),
            .PROT_LIMIT (16'h03FF)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .stb     (stb[g]),
            .wr      (wr[g]),
            .addr    (addr[g]),
            .data_in (din[g]),
            .priv_lvl(priv[g]),
            .ack     (ack[g]),
            .data_out(dout[g]),
            .viol    (viol[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int waitOf(int g);
        return (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: update the memory copy and queue what the DUT should return.
    task automatic pushExpect(input int g, input logic w, input logic [15:0] a,
                              input logic [7:0] d, input logic p);
        exp_t e;
        logic den;
        den = !p && (a >= 16'h0300) && (a <= 16'h03FF);
        if (w) begin
            if (!den) mdl[g][a[9:0]] = d;
        end else begin
            lastRd[g] = den ? 8'h00 : mdl[g][a[9:0]];
        end
        e.inst = g;
        e.cyc  = cyc + 1 + waitOf(g);
        e.data = lastRd[g];
        e.viol = den;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input int g, input logic w, input logic [15:0] a,
                                 input logic [7:0] d, input logic p);
        @(negedge clk);
        stb[g]  = 1'b1;
        wr[g]   = w;
        addr[g] = a;
        din[g]  = d;
        priv[g] = p;
        pushExpect(g, w, a, d, p);
        @(negedge clk);
        stb[g]  = 1'b0;
        wr[g]   = ~w;
        addr[g] = ~a;
        din[g]  = ~d;
        priv[g] = ~p;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checkOutput("ack_timeout", 32'(sbq.size()), 0);
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (viol[g] && !ack[g]) checkOutput("viol_without_ack", 1, 0);
                if (ack[g]) begin
                    if (sbq.size() == 0) begin
                        checkOutput("spurious_ack", 1, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        checkOutput("ack_inst", 32'(g), 32'(e.inst));
                        checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
                        checkOutput("data_out", {24'h0, dout[g]}, {24'h0, e.data});
                        checkOutput("viol", {31'h0, viol[g]}, {31'h0, e.viol});
                    end
                end
            end
        end
    end

    initial begin
        nCompared = 0;
        nFailed   = 0;
        rst  = 1'b1;
        stb  = '0;
        wr   = '0;
        priv = '0;
        for (int g = 0; g < 3; g++) begin
            addr[g]   = 16'h0;
            din[g]    = 8'h0;
            lastRd[g] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checkOutput("rst_ack", {31'h0, ack[g]}, 0);
            checkOutput("rst_viol", {31'h0, viol[g]}, 0);
            checkOutput("rst_dout", {24'h0, dout[g]}, 0);
        end
        rst = 1'b0;

        // Latency, read-back and aliasing with two wait states
        applyStimulus(0, 1, 16'h0010, 8'hA5, 0); waitDone();
        applyStimulus(0, 0, 16'h0010, 8'h00, 0); waitDone();
        applyStimulus(0, 1, 16'h0410, 8'h3C, 0); waitDone();
        applyStimulus(0, 0, 16'h0010, 8'h00, 0); waitDone();

        // Protected window, including both edges and the addresses just outside it
        applyStimulus(0, 1, 16'h0300, 8'h77, 1); waitDone();
        applyStimulus(0, 1, 16'h0300, 8'h11, 0); waitDone();
        applyStimulus(0, 0, 16'h0300, 8'h00, 0); waitDone();
        applyStimulus(0, 0, 16'h0300, 8'h00, 1); waitDone();
        applyStimulus(0, 1, 16'h03FF, 8'h99, 0); waitDone();
        applyStimulus(0, 1, 16'h02FF, 8'h42, 0); waitDone();
        applyStimulus(0, 0, 16'h02FF, 8'h00, 0); waitDone();
        applyStimulus(0, 1, 16'h0400, 8'h24, 0); waitDone();
        applyStimulus(0, 0, 16'h0000, 8'h00, 1); waitDone();

        // A reset during WAIT drops the pending write
        applyStimulus(0, 1, 16'h0020, 8'h5A, 0); waitDone();
        @(negedge clk);
        stb[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0020; din[0] = 8'hEE; priv[0] = 1'b0;
        @(negedge clk);
        stb[0] = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lastRd[0] = 8'h00;
        checkOutput("rst_mid_ack", {31'h0, ack[0]}, 0);
        checkOutput("rst_mid_dout", {24'h0, dout[0]}, 0);
        repeat (6) @(negedge clk);
        applyStimulus(0, 0, 16'h0020, 8'h00, 0); waitDone();

        // Zero wait states: stb held high for three back-to-back reads
        applyStimulus(1, 1, 16'h0040, 8'h11, 0); waitDone();
        applyStimulus(1, 1, 16'h0041, 8'h22, 0); waitDone();
        applyStimulus(1, 1, 16'h0042, 8'h33, 0); waitDone();
        applyStimulus(1, 1, 16'h007F, 8'hEE, 0); waitDone();
        applyStimulus(1, 0, 16'h0041, 8'h00, 0); waitDone();
        @(negedge clk);
        stb[1] = 1'b1; wr[1] = 1'b0; priv[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[1] = 16'h0040 + 16'(k);
            pushExpect(1, 0, addr[1], 8'h00, 0);
            @(negedge clk);
            addr[1] = 16'h007F;
            @(negedge clk);
        end
        stb[1] = 1'b0;
        waitDone();

        // Three wait states with stb dropped after one cycle
        applyStimulus(2, 1, 16'h0100, 8'h55, 0); waitDone();
        applyStimulus(2, 0, 16'h0100, 8'h00, 0); waitDone();

        // Reset takes priority over a same-cycle strobe
        @(negedge clk);
        rst = 1'b1; stb[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'h0100; din[2] = 8'hC3; priv[2] = 1'b1;
        @(negedge clk);
        rst = 1'b0; stb[2] = 1'b0;
        lastRd[2] = 8'h00;
        repeat (8) @(negedge clk);
        applyStimulus(2, 0, 16'h0100, 8'h00, 1); waitDone();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/oc8051_xram_responder.md
Name: oc8051_xram_responder

Overview:
Single-port external-RAM slave that serves the shared stb/wr/addr/data_in/ack/data_out bus driven by the processor arbiter. It has a programmable number of wait states and privilege-based write/read protection for one address window. It also emits a violation pulse. It sits below the arbiter and is the only responder on the shared bus.

Parameters:
ADDR_W, 10, implemented address bits; array depth = 2**ADDR_W bytes; addr[15:ADDR_W] ignored (aliasing).
WAIT_CYCLES, 2, extra cycles between request capture and ack (0..15).
PROT_BASE, 16'h0300, first address of protected window (inclusive, full 16-bit compare).
PROT_LIMIT, 16'h03FF, last address of protected window (inclusive).

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
stb  in  1  request strobe from arbiter.
wr  in  1  1 = write, 0 = read; valid with stb.
addr  in  16  byte address; valid with stb.
data_in  in  8  write data; valid with stb.
priv_lvl  in  1  1 = privileged, 0 = user; valid with stb.
ack  out  1  one-cycle completion pulse.
data_out  out  8  read data, valid while ack = 1.
viol  out  1  one-cycle pulse coincident with ack when access denied.

Behaviour:
- Reset values: ack = 0, data_out = 8'h00, viol = 0, FSM = IDLE, wait counter = 0. Array contents are not cleared.
- FSM states: IDLE, WAIT, ACK. All outputs registered.
- IDLE: when stb = 1 at a rising edge, latch wr, addr, data_in, priv_lvl and load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, otherwise go to ACK. When stb = 0, stay in IDLE.
- WAIT: decrement the counter each edge. When the counter reaches 1 at an edge, go to ACK.
- ACK: ack = 1 for exactly one cycle, then unconditionally return to IDLE.
- Latency: stb sampled at edge E0 → ack high in the cycle after edge E0+WAIT_CYCLES. WAIT_CYCLES = 0 → ack in the cycle immediately after the stb cycle.
- Back-to-back: stb still high in the cycle after ack is a new request, captured from IDLE. Minimum request period is WAIT_CYCLES+2 cycles.
- Latched request values are used from capture onward. Changes of stb, addr, wr, data_in or priv_lvl during WAIT/ACK are ignored. Dropping stb mid-request does not cancel the request; ack is still issued.
- Denied access: denied = (priv_lvl_latched == 0) && PROT_BASE <= addr_latched <= PROT_LIMIT.
- Read: data_out is loaded with mem[addr_latched[ADDR_W-1:0]] on entry to ACK, or 8'h00 if denied. data_out holds its value after ack falls, until the next read completes.
- Write: mem is updated at the edge entering ACK, and only if not denied. data_out is unchanged by writes.
- viol = denied, registered alongside ack. It is never high without ack.
- Read-after-write to the same address in the next transaction returns the new data.
- rst asserted in any state: next cycle is IDLE with ack = 0, viol = 0. A write not yet committed (reset before the ACK-entry edge) is dropped. rst has priority over stb in the same cycle.

Test Plan:
- WAIT_CYCLES = 2: write 8'hA5 to 16'h0010 (priv 0), stb at edge 0 → ack high during cycle 3 only, viol = 0. Then read 16'h0010 → data_out = 8'hA5 with ack.
- Aliasing, ADDR_W = 10: write 8'h3C to 16'h0410, read 16'h0010 → 8'h3C.
- Protection: priv 1 writes 8'h77 to 16'h0300 → no viol. Priv 0 write 8'h11 to 16'h0300 → ack with viol = 1, memory unchanged. Priv 0 read of 16'h0300 → data_out = 8'h00 with viol = 1. Priv 1 read of 16'h0300 → 8'h77.
- Back-to-back: stb held high for 3 reads, WAIT_CYCLES = 0 → ack in cycles 1, 3, 5. Each read returns the address latched at its capture edge. Addr changed during ACK cycles is ignored.
- Reset mid-operation: write 8'hEE to 16'h0020 (old value 8'h5A), rst pulsed during WAIT → no ack, FSM IDLE. Subsequent read of 16'h0020 → 8'h5A.
- Stb dropped after one cycle (WAIT_CYCLES = 3) → ack still pulses once, 4 cycles after capture.
